// File: rtl/seq_startup_pkg.sv
// seq_startup_pkg: shared state encoding and counter widths for the startup controller.
package seq_startup_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PHS = 3'd1,
    S_GO       = 3'd2,
    S_CAL_WAIT = 3'd3,
    S_RESTART  = 3'd4,
    S_DONE     = 3'd5,
    S_FAIL     = 3'd6
  } state_e;
  localparam int ATT_W = 4;
endpackage

// File: rtl/seq_startup_ctrl_bit_sync.sv
// seq_bit_sync: multi-flop synchroniser for one asynchronous bit with a configurable reset value.
module seq_bit_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) sync_q <= {STAGES{RST_VAL}};
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/seq_startup_ctrl.sv
// seq_startup_ctrl: gates calibration start on PLL phase-shift idle, supervises calibration
// with timeout, bounded retries with a sequencer core reset, user recalibration and sticky status.
module seq_startup_ctrl
  import seq_startup_pkg::*;
#(
  parameter int NUM_PHS     = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CAL_TIMEOUT = 20000000,
  parameter int TIMER_WIDTH = 25,
  parameter int MAX_RETRIES = 3,
  parameter int RESET_HOLD  = 8,
  parameter int BYPASS_FSM  = 0
) (
  input  logic               seq_clk,
  input  logic               reset_seq_n,
  input  logic               ctl_init_done,
  input  logic [NUM_PHS-1:0] phs_shft_busy,
  input  logic               recal_req,
  input  logic               seq_cal_done,
  input  logic               seq_cal_success,
  output logic               ctl_init_done_for_seq,
  output logic               phs_shft_busy_for_seq,
  output logic               seq_core_reset_n,
  output logic               cal_done,
  output logic               cal_fail,
  output logic [ATT_W-1:0]   cal_attempts,
  output logic [2:0]         startup_state
);
  localparam bit BYP = (BYPASS_FSM != 0);
  logic [NUM_PHS-1:0]     busy_sync;
  logic                   busy_s;
  state_e                 state_q, state_d;
  logic                   en_q, done_q, fail_q, fail_d, core_rst_n_q;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [ATT_W-1:0]       att_q, att_d;
  logic                   timeout, hold_over, last_try;
  genvar i;
  for (i = 0; i < NUM_PHS; i++) begin : g_sync
    seq_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
      .clk_i (seq_clk),
      .rst_ni(reset_seq_n),
      .d_i   (phs_shft_busy[i]),
      .q_o   (busy_sync[i])
    );
  end
  assign busy_s    = |busy_sync;
  assign timeout   = timer_q == TIMER_WIDTH'(CAL_TIMEOUT - 1);
  assign hold_over = timer_q == TIMER_WIDTH'(RESET_HOLD - 1);
  assign last_try  = att_q == ATT_W'(MAX_RETRIES);
  always_comb begin
    state_d = state_q;
    att_d   = att_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE:     if (ctl_init_done) state_d = busy_s ? S_WAIT_PHS : S_GO;
      S_WAIT_PHS: if (!busy_s) state_d = S_GO;
      S_GO: begin
        state_d = S_CAL_WAIT;
        att_d   = att_q + 1'b1;
      end
      S_CAL_WAIT: begin
        // success outranks a failure report or a timeout in the same cycle
        if (seq_cal_done && seq_cal_success) state_d = S_DONE;
        else if (seq_cal_done || timeout) begin
          state_d = last_try ? S_FAIL : S_RESTART;
          fail_d  = fail_q | last_try;
        end
      end
      S_RESTART:  if (hold_over) state_d = S_IDLE;
      S_DONE: if (recal_req) begin
        state_d = S_RESTART;
        att_d   = '0;
      end
      S_FAIL: if (recal_req) begin
        state_d = S_RESTART;
        att_d   = '0;
        fail_d  = 1'b0;
      end
      default:    state_d = S_IDLE;
    endcase
    // losing controller init aborts everything except the sticky failure flag
    if (!ctl_init_done && state_q != S_IDLE && state_q != S_RESTART) begin
      state_d = S_IDLE;
      att_d   = '0;
      fail_d  = fail_q;
    end
    timer_d = (state_d == state_q && (state_q == S_CAL_WAIT || state_q == S_RESTART)) ?
              timer_q + 1'b1 : '0;
    if (BYP) begin
      state_d = S_IDLE;
      att_d   = '0;
      fail_d  = 1'b0;
      timer_d = '0;
    end
  end
  always_ff @(posedge seq_clk) begin
    if (!reset_seq_n) begin
      state_q      <= S_IDLE;
      en_q         <= 1'b0;
      timer_q      <= '0;
      att_q        <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= state_d == S_CAL_WAIT || state_d == S_DONE;
      timer_q      <= timer_d;
      att_q        <= att_d;
      done_q       <= state_d == S_DONE;
      fail_q       <= fail_d;
      core_rst_n_q <= state_d != S_RESTART;
    end
  end
  assign ctl_init_done_for_seq = BYP ? ctl_init_done : en_q & ctl_init_done;
  assign phs_shft_busy_for_seq = BYP ? |phs_shft_busy : en_q & busy_s;
  assign seq_core_reset_n      = core_rst_n_q;
  assign cal_done              = BYP ? seq_cal_done & seq_cal_success : done_q;
  assign cal_fail              = fail_q;
  assign cal_attempts          = att_q;
  assign startup_state         = state_q;
endmodule

// File: tb/tb_seq_startup_ctrl.sv
// tb_seq_startup_ctrl: directed and randomized checks of the startup controller against
// expectations derived from attempt/timeout/hold arithmetic, plus a bypass instance.
module tb_seq_startup_ctrl;
  localparam int TMO  = 100;
  localparam int MAXR = 3;
  localparam int HOLD = 8;
  localparam int SYNC = 2;
  localparam int ST_IDLE = 0, ST_WAIT = 1, ST_GO = 2, ST_CW = 3, ST_RST = 4, ST_DONE = 5, ST_FAIL = 6;
  logic       seq_clk = 1'b0;
  logic       reset_seq_n, ctl_init_done, recal_req, seq_cal_done, seq_cal_success;
  logic [1:0] phs_shft_busy;
  logic       m_ctl, m_phs, m_core_rst_n, m_done, m_fail;
  logic [3:0] m_att;
  logic [2:0] m_state;
  logic       b_ctl, b_phs, b_core_rst_n, b_done, b_fail;
  logic [3:0] b_att;
  logic [2:0] b_state;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  always #5 seq_clk = ~seq_clk;
  seq_startup_ctrl #(.NUM_PHS(2), .SYNC_STAGES(SYNC), .CAL_TIMEOUT(TMO), .TIMER_WIDTH(25),
    .MAX_RETRIES(MAXR), .RESET_HOLD(HOLD), .BYPASS_FSM(0)) u_dut (
    .seq_clk(seq_clk), .reset_seq_n(reset_seq_n), .ctl_init_done(ctl_init_done),
    .phs_shft_busy(phs_shft_busy), .recal_req(recal_req), .seq_cal_done(seq_cal_done),
    .seq_cal_success(seq_cal_success), .ctl_init_done_for_seq(m_ctl),
    .phs_shft_busy_for_seq(m_phs), .seq_core_reset_n(m_core_rst_n), .cal_done(m_done),
    .cal_fail(m_fail), .cal_attempts(m_att), .startup_state(m_state));
  seq_startup_ctrl #(.NUM_PHS(2), .SYNC_STAGES(SYNC), .CAL_TIMEOUT(TMO), .TIMER_WIDTH(25),
    .MAX_RETRIES(MAXR), .RESET_HOLD(HOLD), .BYPASS_FSM(1)) u_byp (
    .seq_clk(seq_clk), .reset_seq_n(reset_seq_n), .ctl_init_done(ctl_init_done),
    .phs_shft_busy(phs_shft_busy), .recal_req(recal_req), .seq_cal_done(seq_cal_done),
    .seq_cal_success(seq_cal_success), .ctl_init_done_for_seq(b_ctl),
    .phs_shft_busy_for_seq(b_phs), .seq_core_reset_n(b_core_rst_n), .cal_done(b_done),
    .cal_fail(b_fail), .cal_attempts(b_att), .startup_state(b_state));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge seq_clk);
    #1;
  endtask
  task automatic wait_state(input int s, input int budget);
    int c = 0;
    while (32'(m_state) != s && c < budget) begin
      tick();
      c++;
    end
    chk("wait_state", 32'(m_state), s);
  endtask
  task automatic count_low(output int n);
    n = 0;
    while (m_core_rst_n === 1'b0 && n < 50) begin
      tick();
      n++;
    end
  endtask
  // Called on the first CAL_WAIT cycle; reports the sequencer result at cycle 'at' (-1: never).
  task automatic run_cw(input int at, input bit ok, output int n);
    n = 0;
    while (n < 300) begin
      seq_cal_done    = (n == at);
      seq_cal_success = (n == at) && ok;
      tick();
      n++;
      if (32'(m_state) != ST_CW) break;
    end
    seq_cal_done    = 1'b0;
    seq_cal_success = 1'b0;
  endtask
  task automatic recal();
    int n;
    recal_req = 1'b1;
    tick();
    recal_req = 1'b0;
    chk("recal_state", 32'(m_state), ST_RST);
    chk("recal_done", 32'(m_done), 0);
    chk("recal_fail", 32'(m_fail), 0);
    chk("recal_att", 32'(m_att), 0);
    count_low(n);
    chk("recal_hold", n, HOLD);
    chk("recal_idle", 32'(m_state), ST_IDLE);
  endtask
  task automatic campaign(input bit force_fail);
    int at, n, exp_n, exp_s;
    bit ok, hit;
    for (int a = 1; a <= MAXR; a++) begin
      wait_state(ST_CW, 20);
      chk("camp_att", 32'(m_att), a);
      chk("camp_en", 32'(m_ctl), 1);
      at    = force_fail ? -1 : int'($urandom_range(0, 130));
      ok    = 1'($urandom_range(0, 1));
      run_cw(at, ok, n);
      hit   = at >= 0 && at < TMO;
      exp_n = hit ? at + 1 : TMO;
      exp_s = (hit && ok) ? ST_DONE : (a == MAXR ? ST_FAIL : ST_RST);
      chk("cw_len", n, exp_n);
      chk("cw_next", 32'(m_state), exp_s);
      if (exp_s == ST_DONE) begin
        chk("done_flag", 32'(m_done), 1);
        chk("done_nofail", 32'(m_fail), 0);
        chk("done_att", 32'(m_att), a);
        return;
      end
      if (exp_s == ST_FAIL) begin
        chk("fail_flag", 32'(m_fail), 1);
        chk("fail_att", 32'(m_att), MAXR);
        chk("fail_en", 32'(m_ctl), 0);
        chk("fail_core", 32'(m_core_rst_n), 1);
        return;
      end
      chk("rst_low", 32'(m_core_rst_n), 0);
      count_low(n);
      chk("retry_hold", n, HOLD);
      chk("retry_idle", 32'(m_state), ST_IDLE);
      chk("retry_keep_att", 32'(m_att), a);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(m_state), ST_IDLE);
    chk({tag, "_done"}, 32'(m_done), 0);
    chk({tag, "_fail"}, 32'(m_fail), 0);
    chk({tag, "_att"}, 32'(m_att), 0);
    chk({tag, "_core"}, 32'(m_core_rst_n), 0);
    chk({tag, "_ctl"}, 32'(m_ctl), 0);
    chk({tag, "_phs"}, 32'(m_phs), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, n;
    reset_seq_n = 1'b0; ctl_init_done = 1'b0; recal_req = 1'b0;
    seq_cal_done = 1'b0; seq_cal_success = 1'b0; phs_shft_busy = 2'b00;
    repeat (3) tick();
    chk_reset_vals("rst");
    chk("byp_core_in_rst", 32'(b_core_rst_n), 0);
    reset_seq_n = 1'b1;
    phs_shft_busy = 2'($urandom_range(1, 3));
    tick();
    chk("core_after_rst", 32'(m_core_rst_n), 1);
    chk("byp_core_after_rst", 32'(b_core_rst_n), 1);
    repeat (3) tick();
    ctl_init_done = 1'b1;
    tick();
    chk("to_wait_phs", 32'(m_state), ST_WAIT);
    chk("wait_en_off", 32'(m_ctl), 0);
    repeat ($urandom_range(1, 5)) tick();
    chk("wait_hold", 32'(m_state), ST_WAIT);
    phs_shft_busy = 2'b00;
    c = 0;
    while (32'(m_state) != ST_GO && c < 20) begin
      tick();
      c++;
    end
    chk("busy_to_go", c, SYNC + 1);
    chk("go_en_off", 32'(m_ctl), 0);
    tick();
    chk("cw_state", 32'(m_state), ST_CW);
    chk("cw_ctl", 32'(m_ctl), 1);
    chk("cw_att", 32'(m_att), 1);
    phs_shft_busy = 2'b10;
    tick();
    chk("phs_sync1", 32'(m_phs), 0);
    tick();
    chk("phs_sync2", 32'(m_phs), 1);
    phs_shft_busy = 2'b00;
    repeat (2) tick();
    chk("phs_clear", 32'(m_phs), 0);
    seq_cal_done = 1'b1; seq_cal_success = 1'b1;
    tick();
    seq_cal_done = 1'b0; seq_cal_success = 1'b0;
    chk("first_done", 32'(m_state), ST_DONE);
    chk("first_cal_done", 32'(m_done), 1);
    chk("first_no_fail", 32'(m_fail), 0);
    chk("first_att", 32'(m_att), 1);
    repeat ($urandom_range(1, 4)) tick();
    chk("done_hold", 32'(m_done), 1);
    recal();
    campaign(1'b1);
    repeat ($urandom_range(1, 4)) tick();
    chk("fail_sticky", 32'(m_fail), 1);
    chk("fail_state_hold", 32'(m_state), ST_FAIL);
    for (int k = 0; k < 4; k++) begin
      recal();
      campaign(1'b0);
    end
    recal();
    wait_state(ST_CW, 20);
    repeat (3) tick();
    ctl_init_done = 1'b0;
    tick();
    chk("abort_state", 32'(m_state), ST_IDLE);
    chk("abort_att", 32'(m_att), 0);
    chk("abort_done", 32'(m_done), 0);
    ctl_init_done = 1'b1;
    #1;
    chk("abort_en_off", 32'(m_ctl), 0);
    tick();
    chk("abort_go", 32'(m_state), ST_GO);
    tick();
    chk("abort_cw_att", 32'(m_att), 1);
    run_cw(TMO - 1, 1'b1, n);
    chk("tie_len", n, TMO);
    chk("tie_done", 32'(m_state), ST_DONE);
    recal();
    campaign(1'b1);
    ctl_init_done = 1'b0;
    tick();
    chk("fabort_state", 32'(m_state), ST_IDLE);
    chk("fabort_fail_held", 32'(m_fail), 1);
    chk("fabort_att", 32'(m_att), 0);
    for (int k = 0; k < 8; k++) begin
      ctl_init_done   = 1'($urandom_range(0, 1));
      phs_shft_busy   = 2'($urandom_range(0, 3));
      seq_cal_done    = 1'($urandom_range(0, 1));
      seq_cal_success = 1'($urandom_range(0, 1));
      #1;
      chk("byp_ctl", 32'(b_ctl), 32'(ctl_init_done));
      chk("byp_phs", 32'(b_phs), (phs_shft_busy != 2'b00) ? 1 : 0);
      chk("byp_done", 32'(b_done), (seq_cal_done && seq_cal_success) ? 1 : 0);
      chk("byp_fail", 32'(b_fail), 0);
      chk("byp_att", 32'(b_att), 0);
      chk("byp_state", 32'(b_state), 0);
      chk("byp_core", 32'(b_core_rst_n), 1);
      tick();
    end
    seq_cal_done = 1'b0; seq_cal_success = 1'b0; phs_shft_busy = 2'b00; ctl_init_done = 1'b1;
    reset_seq_n = 1'b0;
    tick();
    reset_seq_n = 1'b1;
    wait_state(ST_CW, 20);
    repeat (5) tick();
    reset_seq_n = 1'b0;
    tick();
    chk_reset_vals("midrst");
    reset_seq_n = 1'b1;
    tick();
    chk("sync_rst_busy", 32'(m_state), ST_WAIT);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
